// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ===========================================================================
// regfile_write_scheduler: two-requester register-file write arbiter with a
// busy scoreboard for RAW/WAW stall.                         Revision: 1.0
// ===========================================================================
module regfile_write_scheduler #(
  parameter int bits            = 32,
  parameter int no_of_registers = 32
) (
  input  logic                               clk,
  input  logic                               async_reset,
  input  logic                               rsv_valid,
  input  logic [$clog2(no_of_registers)-1:0] rsv_addr,
  input  logic [$clog2(no_of_registers)-1:0] rs1_addr,
  input  logic [$clog2(no_of_registers)-1:0] rs2_addr,
  output logic                               stall,
  output logic [no_of_registers-1:0]         busy,
  input  logic                               req0_valid,
  input  logic [$clog2(no_of_registers)-1:0] req0_addr,
  input  logic [bits-1:0]                    req0_data,
  output logic                               req0_ready,
  input  logic                               req1_valid,
  input  logic [$clog2(no_of_registers)-1:0] req1_addr,
  input  logic [bits-1:0]                    req1_data,
  output logic                               req1_ready,
  output logic [no_of_registers-1:0]         wr_en,
  output logic [bits-1:0]                    wr_data
);

  localparam int c_aw = $clog2(no_of_registers);

  logic                       r_ptr;
  logic [no_of_registers-1:0] r_busy;
  logic [no_of_registers-1:0] r_wr_en;
  logic [bits-1:0]            r_wr_data;

  logic                       w_grant0;
  logic                       w_grant1;
  logic                       w_xfer;
  logic [c_aw-1:0]            w_addr;
  logic [bits-1:0]            w_data;
  logic                       w_write;
  logic [no_of_registers-1:0] w_one;
  logic [no_of_registers-1:0] w_wr_dec;
  logic [no_of_registers-1:0] w_rsv_dec;
  logic                       w_hazard;
  logic                       w_set;

  // r_ptr == 0 favours req0 under contention, 1 favours req1
  always_comb begin
    w_grant0 = !async_reset && req0_valid && (!req1_valid || !r_ptr);
    w_grant1 = !async_reset && req1_valid && (!req0_valid ||  r_ptr);
    w_xfer   = w_grant0 || w_grant1;
    w_addr   = w_grant0 ? req0_addr : req1_addr;
    w_data   = w_grant0 ? req0_data : req1_data;
    w_write  = w_xfer && (w_addr != '0);
  end

  always_comb begin
    w_one     = {{(no_of_registers-1){1'b0}}, 1'b1};
    w_wr_dec  = w_write ? (w_one << w_addr) : '0;
    w_rsv_dec = w_one << rsv_addr;
    w_hazard  = (r_busy[rs1_addr] && (rs1_addr != '0)) ||
                (r_busy[rs2_addr] && (rs2_addr != '0)) ||
                (rsv_valid && (rsv_addr != '0) && r_busy[rsv_addr]);
    w_set     = !async_reset && rsv_valid && !w_hazard && (rsv_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (async_reset) begin
      r_ptr     <= 1'b0;
      r_busy    <= '0;
      r_wr_en   <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_xfer) begin
        r_ptr <= w_grant0;
      end
      // Clear first so a same-edge reservation of the same register wins
      r_busy  <= (r_busy & ~w_wr_dec) | (w_set ? w_rsv_dec : '0);
      r_wr_en <= w_wr_dec;
      if (w_write) begin
        r_wr_data <= w_data;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign stall      = !async_reset && w_hazard;
  assign busy       = r_busy;
  assign wr_en      = r_wr_en;
  assign wr_data    = r_wr_data;

endmodule
`default_nettype wire

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the single register-file write port between two writeback requesters: req0 (ALU writeback) and req1 (load unit).
- Drives the one-hot per-register write enables and the write data that feed the enable-gated register cells.
- Keeps a busy scoreboard of reserved destination registers and raises stall for RAW and WAW hazards.
- Sits between the issue/writeback stages and the register file.

Parameters:
- bits, 32, data width of each register.
- no_of_registers, 32, number of architectural registers (power of two); address width is clog2(no_of_registers).

Ports:
- clk  input  1  clock, rising edge.
- async_reset  input  1  reset, synchronous and active-high.
- rsv_valid  input  1  issue stage requests to reserve a destination register.
- rsv_addr  input  clog2(no_of_registers)  destination register to reserve.
- rs1_addr  input  clog2(no_of_registers)  source 1 of the instruction in issue.
- rs2_addr  input  clog2(no_of_registers)  source 2 of the instruction in issue.
- stall  output  1  issue must hold; reservation not taken.
- busy  output  no_of_registers  scoreboard; bit i set means register i has a pending write.
- req0_valid  input  1  ALU writeback valid.
- req0_addr  input  clog2(no_of_registers)  ALU destination register.
- req0_data  input  bits  ALU result.
- req0_ready  output  1  req0 is granted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready: same as req0, for the load unit.
- wr_en  output  no_of_registers  one-hot write enables to the register cells.
- wr_data  output  bits  write data to all register cells.

Behaviour:
- Reset (async_reset high at a rising edge):
  - busy=0, wr_en=0, wr_data=0, priority pointer set to req0.
  - req0_ready, req1_ready and stall are forced to 0 while async_reset is high.
  - Reset wins over every other event in the same cycle. An accepted request in that cycle is dropped and produces no write.
- Arbitration (combinational grant):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester named by the pointer is granted; the other gets ready=0.
  - Neither valid: both ready=0.
  - Never both readies high in the same cycle.
  - A transfer happens when valid && ready at the clock edge.
  - After any transfer, the pointer moves to the requester that was not granted. Strict alternation under contention; no starvation.
  - A requester keeps its valid, addr and data stable until it sees ready.
- Write path (1-cycle latency, registered):
  - On a transfer with addr != 0: in the next cycle, wr_en = 1 << addr and wr_data = the granted data.
  - On a transfer with addr == 0: the request is accepted (ready=1), wr_en stays 0, and x0 is never written.
  - No transfer: wr_en=0 next cycle; wr_data holds its last value.
  - Peak throughput is one write per cycle.
- Scoreboard:
  - stall = (busy[rs1_addr] && rs1_addr!=0) || (busy[rs2_addr] && rs2_addr!=0) || (rsv_valid && rsv_addr!=0 && busy[rsv_addr]).
  - stall is combinational, the same cycle as its inputs.
  - Reservation: rsv_valid && !stall && rsv_addr!=0 sets busy[rsv_addr] at the edge. An address of 0 never sets a bit.
  - Clear: a transfer with addr!=0 clears busy[addr] at the same edge as acceptance, so stall can drop in the cycle wr_en is asserted.
  - Same edge, set and clear on the same address: set wins and the bit stays 1.
  - Different addresses: both take effect.
  - A transfer to a register that is not busy is legal; it writes, and busy stays 0.
- Arithmetic:
  - Enables are decoded as 1 << addr, truncated to no_of_registers bits.
  - No wrap-around state other than the 1-bit priority pointer.

Test Plan:
- Reset then idle: async_reset=1 for 2 cycles, then no valids → wr_en=0, wr_data=0, busy=0, stall=0, both readies 0.
- Single write: req0_valid=1, addr=5, data=0xDEADBEEF → req0_ready=1 that cycle; next cycle wr_en=0x00000020, wr_data=0xDEADBEEF; the following cycle wr_en=0.
- Contention: req0 (addr 3, 0x11) and req1 (addr 4, 0x22) held valid from reset:
  - Cycle 1: req0 granted.
  - Cycle 2: req1 granted.
  - wr_en sequence 0x8 then 0x10.
  - Repeat with req0 only re-asserted after its grant and confirm alternation.
- Hazard: reserve addr 7 → busy=0x80. Next cycle rs1_addr=7 → stall=1. A req1 write to addr 7 clears busy → stall=0 in the cycle wr_en=0x80.
- x0 rules: rsv_addr=0 and a req0 write to addr 0 → busy unchanged, wr_en=0, req0_ready=1, stall=0 with rs1=rs2=0.
- Simultaneous set/clear: busy[9]=1; same cycle, a write to 9 is accepted and rsv_valid=1 with rsv_addr=9 (stall=1 → no set; busy[9] clears). Then pre-clear case: busy[9]=0, rsv 9 with a write to 9 → busy[9]=1 after the edge.
